// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS_DEF   = 8;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DATA_BITS_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx metastability synchronizer with falling-edge detect
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to 1 so release of reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller with valid/ready byte output
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clk_bps,
  output logic                 band_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 band_q, band_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s;
  logic                 fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rx_s(rx_s),
    .fall(fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      band_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (clk_bps) state_d = rx_s ? IDLE : DATA;
      DATA:    if (clk_bps && (cnt_q == LAST_BIT)) state_d = STOP;
      STOP:    if (clk_bps) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The baud generator is enabled for every non-idle state, so band_sig
  // follows the registered state transition exactly.
  always_comb begin
    band_d  = (state_d != IDLE);
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (clk_bps) begin
      case (state_q)
        START: cnt_d = '0;
        DATA: begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
        STOP: begin
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign band_sig  = band_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a baud generator model
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int BIT_CLK   = 109;
  localparam int FIRST_BPS = 55;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clk_bps;
  logic       band_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0, valid_cyc = 0, ferr_cyc = 0, ovr_cyc = 0, band_rise = 0;
  int band_fall_cyc = 0, last_bps_cyc = 0;
  logic band_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .clk_bps  (clk_bps),
    .band_sig (band_sig),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Baud generator model: first strobe 55 clk after enable, then every 109 clk.
  initial begin
    int cnt;
    cnt = 0;
    clk_bps = 1'b0;
    forever begin
      @(negedge clk);
      if (!band_sig) begin
        cnt = 0;
        clk_bps = 1'b0;
      end else begin
        cnt++;
        clk_bps = (cnt == FIRST_BPS) ||
                  (cnt > FIRST_BPS && ((cnt - FIRST_BPS) % BIT_CLK) == 0);
      end
    end
  end

  // Monitor and scoreboard: pop the expected byte on every accepted handshake.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rx_valid) valid_cyc++;
      if (frame_err) ferr_cyc++;
      if (overrun) ovr_cyc++;
      if (band_sig && !band_prev) band_rise++;
      if (!band_sig && band_prev) band_fall_cyc = cyc;
      if (clk_bps && band_sig) last_bps_cyc = cyc;
      band_prev = band_sig;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got byte %0h, expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {24'd0, rx_data}, {24'd0, e});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       gap_low;
    int         exp_ferr;
    int         exp_valid;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, f0, o0, b0;
    vecs[0] = '{8'hA5, 1'b1, 60,  1'b0, 0, 1};
    vecs[1] = '{8'h55, 1'b0, 300, 1'b1, 1, 0};
    vecs[2] = '{8'h12, 1'b1, 60,  1'b0, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 0,   1'b0, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 60,  1'b0, 0, 1};

    rst = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_band", {31'd0, band_sig}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc; b0 = band_rise;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].gap_low) begin
        rx = 1'b0;
        repeat (vecs[i].gap) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
      end else begin
        rx = 1'b1;
        repeat (vecs[i].gap) @(negedge clk);
      end
      check($sformatf("v%0d_valid_cycles", i), valid_cyc - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_ferr_cycles", i), ferr_cyc - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr_cycles", i), ovr_cyc - o0, 0);
      check($sformatf("v%0d_band_rises", i), band_rise - b0, 1);
      check($sformatf("v%0d_band_drop_lat", i), band_fall_cyc - last_bps_cyc, 1);
      if (vecs[i].gap != 0) check($sformatf("v%0d_idle", i), {31'd0, band_sig}, 32'd0);
    end

    // Held byte followed by an overrun frame.
    rx_ready = 1'b0;
    v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("hold_valid", {31'd0, rx_valid}, 32'd1);
    check("hold_data", {24'd0, rx_data}, 32'h3C);
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("ovr_cycles", ovr_cyc - o0, 1);
    check("ovr_ferr", ferr_cyc - f0, 0);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
    check("ovr_valid_kept", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("accept_clears_valid", {31'd0, rx_valid}, 32'd0);

    // Short low glitch on an idle line is a false start.
    v0 = valid_cyc; f0 = ferr_cyc; b0 = band_rise;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_band_rise", band_rise - b0, 1);
    check("glitch_band_drop_lat", band_fall_cyc - last_bps_cyc, 1);
    check("glitch_valid", valid_cyc - v0, 0);
    check("glitch_ferr", ferr_cyc - f0, 0);

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLK + 50) @(negedge clk);
    check("pre_rst_band", {31'd0, band_sig}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_band", {31'd0, band_sig}, 32'd0);
    check("arst_data", {24'd0, rx_data}, 32'd0);
    check("arst_valid", {31'd0, rx_valid}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    v0 = valid_cyc; f0 = ferr_cyc;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_valid", valid_cyc - v0, 1);
    check("post_rst_ferr", ferr_cyc - f0, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
